// File: rtl/bp_me_burst_arb.sv
// N-to-1 BedRock burst arbiter: round-robin header arbitration, grant held through the last
// data beat, sticky flag for messages longer than max_beats_p.
module bp_me_burst_arb #(
    parameter int num_src_p      = 2,
    parameter int header_width_p = 128,
    parameter int data_width_p   = 64,
    parameter int max_beats_p    = 8,
    localparam int lg_num_src_lp = (num_src_p > 1) ? $clog2(num_src_p) : 1
) (
    input  logic                              clk_i,
    input  logic                              reset_i,

    input  logic [num_src_p*header_width_p-1:0] src_header_i,
    input  logic [num_src_p-1:0]              src_header_has_data_i,
    input  logic [num_src_p-1:0]              src_header_v_i,
    output logic [num_src_p-1:0]              src_header_ready_and_o,
    input  logic [num_src_p*data_width_p-1:0] src_data_i,
    input  logic [num_src_p-1:0]              src_data_last_i,
    input  logic [num_src_p-1:0]              src_data_v_i,
    output logic [num_src_p-1:0]              src_data_ready_and_o,

    output logic [header_width_p-1:0]         header_o,
    output logic                              header_has_data_o,
    output logic                              header_v_o,
    input  logic                              header_ready_and_i,
    output logic [data_width_p-1:0]           data_o,
    output logic                              data_last_o,
    output logic                              data_v_o,
    input  logic                              data_ready_and_i,

    output logic [lg_num_src_lp-1:0]          src_id_o,
    output logic                              burst_error_o
);

    localparam int cnt_width_lp = $clog2(max_beats_p + 1);

    typedef enum logic [1:0] {e_idle, e_header, e_data} state_e;

    state_e                   state_r, state_n;
    logic [lg_num_src_lp-1:0] grant_r, grant_n;
    logic [lg_num_src_lp-1:0] last_r, last_n;
    logic [cnt_width_lp-1:0]  beat_cnt_r, beat_cnt_n;
    logic                     err_r, err_n;

    logic [lg_num_src_lp-1:0] pick, cand;
    logic                     pick_v;

    logic [header_width_p-1:0] src_header_arr [num_src_p];
    logic [data_width_p-1:0]   src_data_arr   [num_src_p];

    for (genvar g = 0; g < num_src_p; g++) begin : g_src
        assign src_header_arr[g] = src_header_i[g*header_width_p +: header_width_p];
        assign src_data_arr[g]   = src_data_i[g*data_width_p +: data_width_p];
    end

    assign header_o          = src_header_arr[grant_r];
    assign header_has_data_o = src_header_has_data_i[grant_r];
    assign data_o            = src_data_arr[grant_r];
    assign data_last_o       = src_data_last_i[grant_r];
    assign src_id_o          = grant_r;
    assign burst_error_o     = err_r;

    // Walk sources starting just after the last winner; first requester found wins.
    always_comb begin
        pick   = '0;
        pick_v = 1'b0;
        cand   = last_r;
        for (int i = 0; i < num_src_p; i++) begin
            cand = (cand == lg_num_src_lp'(num_src_p - 1)) ? '0 : cand + 1'b1;
            if (!pick_v && src_header_v_i[cand]) begin
                pick   = cand;
                pick_v = 1'b1;
            end
        end
    end

    always_comb begin
        state_n                = state_r;
        grant_n                = grant_r;
        last_n                 = last_r;
        beat_cnt_n             = beat_cnt_r;
        err_n                  = err_r;
        src_header_ready_and_o = '0;
        src_data_ready_and_o   = '0;
        header_v_o             = 1'b0;
        data_v_o               = 1'b0;

        unique case (state_r)
            e_idle: begin
                if (pick_v) begin
                    grant_n = pick;
                    state_n = e_header;
                end
            end
            e_header: begin
                header_v_o                      = src_header_v_i[grant_r];
                src_header_ready_and_o[grant_r] = header_ready_and_i;
                if (header_v_o && header_ready_and_i) begin
                    last_n     = grant_r;
                    beat_cnt_n = '0;
                    state_n    = header_has_data_o ? e_data : e_idle;
                end
            end
            e_data: begin
                data_v_o                      = src_data_v_i[grant_r];
                src_data_ready_and_o[grant_r] = data_ready_and_i;
                if (data_v_o && data_ready_and_i) begin
                    if (beat_cnt_r != cnt_width_lp'(max_beats_p)) begin
                        beat_cnt_n = beat_cnt_r + 1'b1;
                    end
                    // Reaching the last legal beat without last means the message overruns.
                    if (beat_cnt_r == cnt_width_lp'(max_beats_p - 1) && !data_last_o) begin
                        err_n = 1'b1;
                    end
                    if (data_last_o) begin
                        state_n = e_idle;
                    end
                end
            end
            default: state_n = e_idle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r    <= e_idle;
            grant_r    <= '0;
            last_r     <= lg_num_src_lp'(num_src_p - 1);
            beat_cnt_r <= '0;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_n;
            grant_r    <= grant_n;
            last_r     <= last_n;
            beat_cnt_r <= beat_cnt_n;
            err_r      <= err_n;
        end
    end

endmodule
